dma_pcie_mi_pasid_ram_slv: RTL and testbench

//  Responder (slave) end of the PASID RAM interface: cycle-accurate model of the PCIe hard-block PASID RAMs.

---
 rtl/dma_pcie_mi_pasid_ram_slv.sv | 243 ++++++++++++++++++++++++
 tb/tb_dma_pcie_mi_pasid_ram_slv.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_pcie_mi_pasid_ram_slv.sv
`default_nettype none
// ============================================================================
//  Module   : dma_pcie_mi_pasid_ram_slv
//  Brief    : Responder end of the PASID RAM interface. Cycle-accurate model
//             of the PCIe hard-block PASID RAMs: NUM_BANKS x 512 x 36b, four
//             9b byte-lanes with per-lane write enable, fixed-latency pipelined
//             reads, corrected/uncorrected error reporting.
//             Optional error injection enabled by `define PASID_RAM_ERR_INJ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_pcie_mi_pasid_ram_slv #(
    parameter int NUM_BANKS = 8,    // 1..8 banks of 512 entries
    parameter int RD_LAT    = 2,    // 1..4 cycles, ren -> rdata
    parameter int CNT_W     = 16    // saturating error counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      addr_i,
    input  logic [3:0]       wen_i,
    input  logic             ren_i,
    input  logic [35:0]      wdata_i,
    output logic [35:0]      rdata_o,
    output logic             cor_o,
    output logic             uncor_o,
`ifdef PASID_RAM_ERR_INJ_EN
    input  logic             inj_cor_i,
    input  logic             inj_uncor_i,
    output logic [CNT_W-1:0] cor_cnt_o,
`endif
    output logic [CNT_W-1:0] uncor_cnt_o
);

    localparam int         c_DEPTH = NUM_BANKS * 512;
    localparam int         c_AW    = $clog2(c_DEPTH);
    localparam logic [3:0] c_NB    = 4'(NUM_BANKS);
    // Pipeline word: {valid, out-of-range, inject-cor, inject-uncor, data}
    localparam int         c_PW    = 40;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             w_oor;
    logic [c_AW-1:0]  w_idx;
    logic [35:0]      w_rd_raw;
    logic [35:0]      w_rd_data;
    logic             w_req_ic;
    logic             w_req_iu;
    logic [c_PW-1:0]  w_req;

    // Banks at or above NUM_BANKS do not exist: writes are dropped and
    // reads report an uncorrectable error with zero data.
    assign w_oor = ({1'b0, addr_i[11:9]} >= c_NB);
    assign w_idx = addr_i[c_AW-1:0];

    // ------------------------------------------------------------------
    // Storage: one array per byte-lane. No reset, contents survive rst_n.
    // The array is read combinationally into the first pipeline register,
    // so a write in the same cycle lands after the read (read-first).
    // ------------------------------------------------------------------
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [8:0] mem_q [c_DEPTH];

        // Lane write, gated by its own enable and by the bank range check
        always_ff @(posedge clk) begin
            if (!w_oor && wen_i[l]) begin
                mem_q[w_idx] <= wdata_i[9*l +: 9];
            end
        end

        assign w_rd_raw[9*l +: 9] = mem_q[w_idx];
    end

    assign w_rd_data = w_oor ? 36'h0 : w_rd_raw;

    // ------------------------------------------------------------------
    // Error injection arming
    // ------------------------------------------------------------------
`ifdef PASID_RAM_ERR_INJ_EN
    logic arm_cor_q;
    logic arm_cor_d;
    logic arm_uncor_q;
    logic arm_uncor_d;
    logic w_eff_cor;
    logic w_eff_uncor;

    // An injection pulse in the same cycle as ren is consumed by that read.
    assign w_eff_cor   = arm_cor_q   | inj_cor_i;
    assign w_eff_uncor = arm_uncor_q | inj_uncor_i;

    // Flags are sticky until the next read consumes them (both clear together)
    always_comb begin
        arm_cor_d   = w_eff_cor;
        arm_uncor_d = w_eff_uncor;
        if (ren_i) begin
            arm_cor_d   = 1'b0;
            arm_uncor_d = 1'b0;
        end
    end

    // Arm flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cor_q   <= 1'b0;
            arm_uncor_q <= 1'b0;
        end else begin
            arm_cor_q   <= arm_cor_d;
            arm_uncor_q <= arm_uncor_d;
        end
    end

    // Uncorrectable wins over correctable; an out-of-range read already
    // reports uncorrectable so a pending correctable is not shown for it.
    assign w_req_iu = ren_i & w_eff_uncor;
    assign w_req_ic = ren_i & w_eff_cor & ~w_eff_uncor & ~w_oor;
`else
    assign w_req_iu = 1'b0;
    assign w_req_ic = 1'b0;
`endif

    assign w_req = {ren_i, w_oor, w_req_ic, w_req_iu, w_rd_data};

    // ------------------------------------------------------------------
    // Read pipeline. The last stage is the output register itself, so only
    // RD_LAT-1 intermediate stages are needed.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_last;

    if (RD_LAT > 1) begin : g_pipe
        logic [c_PW-1:0] pipe_q [RD_LAT-1];

        // Shift the request word one stage per clock; reset drops in-flight reads
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < RD_LAT-1; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                pipe_q[0] <= w_req;
                for (int k = 1; k < RD_LAT-1; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign w_last = pipe_q[RD_LAT-2];
    end else begin : g_direct
        assign w_last = w_req;
    end

    logic        w_last_vld;
    logic        w_last_oor;
    logic        w_last_ic;
    logic        w_last_iu;
    logic [35:0] w_last_data;

    assign w_last_vld  = w_last[39];
    assign w_last_oor  = w_last[38];
    assign w_last_ic   = w_last[37];
    assign w_last_iu   = w_last[36];
    assign w_last_data = w_last[35:0];

    // ------------------------------------------------------------------
    // Response stage and error counters
    // ------------------------------------------------------------------
    logic [35:0]      rdata_q;
    logic [35:0]      rdata_d;
    logic             cor_q;
    logic             cor_d;
    logic             uncor_q;
    logic             uncor_d;
    logic [CNT_W-1:0] uncor_cnt_q;
    logic [CNT_W-1:0] uncor_cnt_d;

    // rdata holds between responses; error flags are one-cycle pulses
    always_comb begin
        rdata_d     = rdata_q;
        cor_d       = 1'b0;
        uncor_d     = 1'b0;
        uncor_cnt_d = uncor_cnt_q;
        if (w_last_vld) begin
            // Injected uncorrectable error corrupts bit 0 of real data only
            rdata_d = w_last_data ^ {35'd0, w_last_iu & ~w_last_oor};
            cor_d   = w_last_ic;
            uncor_d = w_last_oor | w_last_iu;
        end
        if (uncor_d && (uncor_cnt_q != {CNT_W{1'b1}})) begin
            uncor_cnt_d = uncor_cnt_q + CNT_W'(1);
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= 36'h0;
            cor_q       <= 1'b0;
            uncor_q     <= 1'b0;
            uncor_cnt_q <= '0;
        end else begin
            rdata_q     <= rdata_d;
            cor_q       <= cor_d;
            uncor_q     <= uncor_d;
            uncor_cnt_q <= uncor_cnt_d;
        end
    end

`ifdef PASID_RAM_ERR_INJ_EN
    logic [CNT_W-1:0] cor_cnt_q;
    logic [CNT_W-1:0] cor_cnt_d;

    // Saturating count of correctable pulses
    always_comb begin
        cor_cnt_d = cor_cnt_q;
        if (cor_d && (cor_cnt_q != {CNT_W{1'b1}})) begin
            cor_cnt_d = cor_cnt_q + CNT_W'(1);
        end
    end

    // Correctable counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cor_cnt_q <= '0;
        end else begin
            cor_cnt_q <= cor_cnt_d;
        end
    end

    assign cor_cnt_o = cor_cnt_q;
`endif

    // Without injection cor_q can never be set, so cor is effectively tied low.
    assign rdata_o     = rdata_q;
    assign cor_o       = cor_q;
    assign uncor_o     = uncor_q;
    assign uncor_cnt_o = uncor_cnt_q;

`ifndef SYNTHESIS
    a_addr_known: assert property (@(posedge clk) disable iff (!rst_n)
        ren_i |-> !$isunknown(addr_i))
        else $error("pasid ram: read issued with unknown address");
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_pcie_mi_pasid_ram_slv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_pcie_mi_pasid_ram_slv
//  Brief    : Self-checking bench for the PASID RAM responder. Directed
//             scenarios followed by random traffic against a reference
//             model built from the read/write/latency rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_pcie_mi_pasid_ram_slv;

    localparam int         NB   = 4;
    localparam int         LAT  = 2;
    localparam int         CW   = 4;
    localparam logic [CW-1:0] SAT = {CW{1'b1}};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [11:0]   addr  = '0;
    logic [3:0]    wen   = '0;
    logic          ren   = 1'b0;
    logic [35:0]   wdata = '0;
    logic          injc  = 1'b0;
    logic          inju  = 1'b0;
    logic [35:0]   rdata;
    logic          cor;
    logic          uncor;
    logic [CW-1:0] uncor_cnt;
`ifdef PASID_RAM_ERR_INJ_EN
    logic [CW-1:0] cor_cnt;
`endif

    always #5 clk = ~clk;

    dma_pcie_mi_pasid_ram_slv #(
        .NUM_BANKS (NB),
        .RD_LAT    (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (addr),
        .wen_i       (wen),
        .ren_i       (ren),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .cor_o       (cor),
        .uncor_o     (uncor),
`ifdef PASID_RAM_ERR_INJ_EN
        .inj_cor_i   (injc),
        .inj_uncor_i (inju),
        .cor_cnt_o   (cor_cnt),
`endif
        .uncor_cnt_o (uncor_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [35:0]   mdl [NB*512];
    logic          s_vld  [8];
    logic [35:0]   s_data [8];
    logic          s_c    [8];
    logic          s_u    [8];
    int            n = 0;
    logic [35:0]   exp_rdata = '0;
    logic          exp_cor   = 1'b0;
    logic          exp_uncor = 1'b0;
    int            exp_ucnt  = 0;
    int            exp_ccnt  = 0;
    logic          arm_c = 1'b0;
    logic          arm_u = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the behavioural model using the current inputs.
    task automatic model_edge();
        int  slot;
        bit  oor;
        bit  effc;
        bit  effu;
        logic [35:0] d;
        oor  = (int'(addr[11:9]) >= NB);
        effc = arm_c | injc;
        effu = arm_u | inju;
        if (ren) begin
            d = oor ? 36'h0 : mdl[addr[10:0]];
            if (effu && !oor) d[0] = ~d[0];
            slot = (n + LAT - 1) % 8;
            s_vld[slot]  = 1'b1;
            s_data[slot] = d;
            s_u[slot]    = oor | effu;
            s_c[slot]    = effc & !effu & !oor;
            arm_c = 1'b0;
            arm_u = 1'b0;
        end else begin
            arm_c = effc;
            arm_u = effu;
        end
        exp_cor   = 1'b0;
        exp_uncor = 1'b0;
        slot = n % 8;
        if (s_vld[slot]) begin
            exp_rdata = s_data[slot];
            exp_cor   = s_c[slot];
            exp_uncor = s_u[slot];
            if (exp_uncor && exp_ucnt < int'(SAT)) exp_ucnt++;
            if (exp_cor && exp_ccnt < int'(SAT)) exp_ccnt++;
            s_vld[slot] = 1'b0;
        end
        if (!oor) begin
            for (int l = 0; l < 4; l++) begin
                if (wen[l]) mdl[addr[10:0]][9*l +: 9] = wdata[9*l +: 9];
            end
        end
        n++;
    endtask

    task automatic check_outputs();
        chk("rdata", {28'd0, rdata}, {28'd0, exp_rdata});
        chk("cor", {63'd0, cor}, {63'd0, exp_cor});
        chk("uncor", {63'd0, uncor}, {63'd0, exp_uncor});
        chk("uncor_cnt", {60'd0, uncor_cnt}, 64'(exp_ucnt));
`ifdef PASID_RAM_ERR_INJ_EN
        chk("cor_cnt", {60'd0, cor_cnt}, 64'(exp_ccnt));
`endif
    endtask

    // One clock cycle: drive, let the edge happen, update model, check.
    task automatic cyc(input logic r, input logic [3:0] w, input logic [11:0] a,
                       input logic [35:0] d, input logic ic, input logic iu);
        ren = r; wen = w; addr = a; wdata = d; injc = ic; inju = iu;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 4'h0, 12'h0, 36'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        ren = 1'b0; wen = 4'h0; injc = 1'b0; inju = 1'b0;
        for (int i = 0; i < 8; i++) s_vld[i] = 1'b0;
        exp_rdata = '0; exp_cor = 1'b0; exp_uncor = 1'b0;
        exp_ucnt = 0; exp_ccnt = 0; arm_c = 1'b0; arm_u = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_rdata", {28'd0, rdata}, 64'd0);
        chk("rst_cor", {63'd0, cor}, 64'd0);
        chk("rst_uncor", {63'd0, uncor}, 64'd0);
        chk("rst_uncor_cnt", {60'd0, uncor_cnt}, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [35:0] rv;
        logic        r;
        logic [3:0]  w;
        logic [11:0] a;
        logic        ic;
        logic        iu;
        for (int i = 0; i < 8; i++) s_vld[i] = 1'b0;
        for (int i = 0; i < NB*512; i++) mdl[i] = '0;

        #2;
        do_reset(2);

        // 1: full write, read back after RD_LAT
        cyc(1'b0, 4'hF, 12'h005, 36'h9_8765_4321, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t1_rdata", {28'd0, rdata}, {28'd0, 36'h9_8765_4321});
        chk("t1_flags", {62'd0, cor, uncor}, 64'd0);

        // 2: lane 1 only (bits 17:9, so bits 17:16 change too)
        cyc(1'b0, 4'b0010, 12'h005, 36'hF_FFFF_FFFF, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t2_lane", {28'd0, rdata}, {28'd0, 36'h9_8767_FF21});

        // 3: read-first on same-cycle write, new data one cycle later
        cyc(1'b1, 4'hF, 12'h005, 36'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        chk("t3_readfirst", {28'd0, rdata}, {28'd0, 36'h9_8767_FF21});
        idle(1);
        chk("t3_newdata", {28'd0, rdata}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) cyc(1'b0, 4'hF, 12'(i), 36'h1_0000_0000 | 36'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'h0, 12'(i), 36'h0, 1'b0, 1'b0);
        idle(2);

        // 4: out-of-range bank
        cyc(1'b1, 4'h0, 12'h800, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t4_oor_data", {28'd0, rdata}, 64'd0);
        chk("t4_oor_uncor", {63'd0, uncor}, 64'd1);
        idle(1);
        chk("t4_uncor_pulse", {63'd0, uncor}, 64'd0);
        chk("t4_uncor_cnt", {60'd0, uncor_cnt}, 64'd1);
        cyc(1'b0, 4'hF, 12'h800, 36'h5_5555_5555, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 12'h000, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t4_no_alias", {28'd0, rdata}, {28'd0, 36'h1_0000_0000});

        cyc(1'b0, 4'hF, 12'h005, 36'hA_BCDE_F012, 1'b0, 1'b0);
`ifdef PASID_RAM_ERR_INJ_EN
        // 5: error injection
        cyc(1'b0, 4'h0, 12'h0, 36'h0, 1'b1, 1'b0);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t5_cor_data", {28'd0, rdata}, {28'd0, 36'hA_BCDE_F012});
        chk("t5_cor", {63'd0, cor}, 64'd1);
        idle(1);
        chk("t5_cor_cnt", {60'd0, cor_cnt}, 64'd1);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b1, 1'b1);
        idle(1);
        chk("t5_uncor_data", {28'd0, rdata}, {28'd0, 36'hA_BCDE_F013});
        chk("t5_both_flags", {62'd0, cor, uncor}, 64'd1);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t5_clean", {28'd0, rdata}, {28'd0, 36'hA_BCDE_F012});
        chk("t5_clean_flags", {62'd0, cor, uncor}, 64'd0);
`endif

        // 6: reset with reads in flight
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 12'h800, 36'h0, 1'b0, 1'b0);
        do_reset(2);
        idle(3);
        chk("t6_post_rst", {27'd0, rdata, uncor}, 64'd0);
        cyc(1'b1, 4'h0, 12'h005, 36'h0, 1'b0, 1'b0);
        idle(1);
        chk("t6_survive", {28'd0, rdata}, {28'd0, 36'hA_BCDE_F012});

        // Random traffic over a small address pool including one bad bank
        for (int b = 0; b < NB; b++) begin
            for (int e = 0; e < 16; e++) begin
                rv = {4'($urandom), $urandom};
                cyc(1'b0, 4'hF, {3'(b), 9'(e)}, rv, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 500; i++) begin
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            a  = {3'($urandom_range(0, NB)), 9'($urandom_range(0, 15))};
            rv = {4'($urandom), $urandom};
            ic = 1'b0;
            iu = 1'b0;
`ifdef PASID_RAM_ERR_INJ_EN
            ic = ($urandom_range(0, 9) == 0);
            iu = ($urandom_range(0, 14) == 0);
`endif
            cyc(r, w, a, rv, ic, iu);
        end
        idle(LAT);

        // Counter saturation
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'h0, 12'h800, 36'h0, 1'b0, 1'b0);
        idle(LAT);
        chk("sat_uncor_cnt", {60'd0, uncor_cnt}, {60'd0, SAT});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
